// File: rtl/ps2_cmd_sched_if.sv
// Bundle of request, write-engine and receive-path signals around the PS/2 command scheduler.
// Signal directions are named from the scheduler's point of view.
interface ps2_cmd_sched_if;
  logic [1:0] i_req;
  logic [7:0] i_cmd0;
  logic [7:0] i_cmd1;
  logic [1:0] o_ack;
  logic [1:0] o_err;
  logic       o_wr_en;
  logic [7:0] o_wr_data;
  logic       i_wr_done;
  logic       i_rx_en;
  logic [7:0] i_rx_data;
  logic       o_rx_en;
  logic [7:0] o_rx_data;
  logic       o_init_done;
  logic       o_init_fail;

  modport master (
    input  i_req, i_cmd0, i_cmd1, i_wr_done, i_rx_en, i_rx_data,
    output o_ack, o_err, o_wr_en, o_wr_data, o_rx_en, o_rx_data, o_init_done, o_init_fail
  );

  modport slave (
    output i_req, i_cmd0, i_cmd1, i_wr_done, i_rx_en, i_rx_data,
    input  o_ack, o_err, o_wr_en, o_wr_data, o_rx_en, o_rx_data, o_init_done, o_init_fail
  );
endinterface

// File: rtl/ps2_cmd_sched.sv
// Host-side PS/2 command scheduler: boot sequence (FF, BAT, F4), then round-robin
// service of two command requesters with FA/FE response checking and resend.
//
// state   | meaning
// B_FF    | start FF (reset) frame
// B_FFW   | wait write engine done for FF
// B_FFA   | wait FA/FE for FF
// B_BAT   | wait AA (BAT pass) / FC (BAT fail)
// B_F4    | start F4 (enable) frame
// B_F4W   | wait write engine done for F4
// B_F4A   | wait FA/FE for F4
// B_FAIL  | boot failed, parked until reset
// S_IDLE  | arbitrate requesters
// S_GRANT | latch winner's command byte
// S_SEND  | pulse write engine start
// S_WAITW | wait write engine done
// S_WAITR | wait device response
module ps2_cmd_sched #(
  parameter logic [23:0] RSP_TMO   = 24'd1_000_000,
  parameter logic [25:0] BAT_TMO   = 26'd37_500_000,
  parameter logic [1:0]  MAX_RETRY = 2'd3
) (
  input  logic             clk,
  input  logic             rst_n,
  ps2_cmd_sched_if.master  bus
);

  typedef enum logic [3:0] {
    B_FF, B_FFW, B_FFA, B_BAT, B_F4, B_F4W, B_F4A, B_FAIL,
    S_IDLE, S_GRANT, S_SEND, S_WAITW, S_WAITR
  } state_t;

  localparam logic [25:0] RSP_LAST = {2'b00, RSP_TMO} - 26'd1;
  localparam logic [25:0] BAT_LAST = BAT_TMO - 26'd1;

  state_t      r_state;
  logic [25:0] r_timer;
  logic [1:0]  r_retry;
  logic        r_ptr;
  logic        r_gnt;
  logic [1:0]  r_ack;
  logic [1:0]  r_err;
  logic        r_wr_en;
  logic [7:0]  r_wr_data;
  logic        r_rx_en;
  logic [7:0]  r_rx_data;
  logic        r_init_done;
  logic        r_init_fail;

  logic        w_fa;
  logic        w_fe;
  logic        w_aa;
  logic        w_fc;
  logic        w_rsp_tmo;
  logic        w_bat_tmo;
  logic        w_can_retry;
  logic        w_win;
  logic        w_fwd;
  logic [7:0]  w_cmd;
  logic [1:0]  w_gvec;
  logic [25:0] w_timer_inc;

  assign w_fa        = bus.i_rx_en && (bus.i_rx_data == 8'hFA);
  assign w_fe        = bus.i_rx_en && (bus.i_rx_data == 8'hFE);
  assign w_aa        = bus.i_rx_en && (bus.i_rx_data == 8'hAA);
  assign w_fc        = bus.i_rx_en && (bus.i_rx_data == 8'hFC);
  assign w_rsp_tmo   = (r_timer == RSP_LAST);
  assign w_bat_tmo   = (r_timer == BAT_LAST);
  assign w_can_retry = (r_retry < MAX_RETRY);
  assign w_timer_inc = (&r_timer) ? r_timer : r_timer + 26'd1;
  // When both request, the side that was not served last wins.
  assign w_win       = (&bus.i_req) ? ~r_ptr : bus.i_req[1];
  assign w_cmd       = r_gnt ? bus.i_cmd1 : bus.i_cmd0;
  assign w_gvec      = r_gnt ? 2'b10 : 2'b01;
  // FA/FE in WAITR are consumed as responses; any other byte after boot is scan traffic.
  assign w_fwd       = r_init_done && bus.i_rx_en && !((r_state == S_WAITR) && (w_fa || w_fe));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= B_FF;
      r_timer     <= '0;
      r_retry     <= '0;
      r_ptr       <= 1'b0;
      r_gnt       <= 1'b0;
      r_ack       <= '0;
      r_err       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_rx_en     <= 1'b0;
      r_rx_data   <= '0;
      r_init_done <= 1'b0;
      r_init_fail <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_ack   <= '0;
      r_err   <= '0;
      r_rx_en <= 1'b0;
      r_timer <= w_timer_inc;
      if (w_fwd) begin
        r_rx_en   <= 1'b1;
        r_rx_data <= bus.i_rx_data;
      end
      case (r_state)
        B_FF: begin
          r_wr_en   <= 1'b1;
          r_wr_data <= 8'hFF;
          r_state   <= B_FFW;
        end
        B_FFW: begin
          if (bus.i_wr_done) begin
            r_timer <= '0;
            r_state <= B_FFA;
          end
        end
        B_FFA: begin
          if (w_fa) begin
            r_retry <= '0;
            r_timer <= '0;
            r_state <= B_BAT;
          end else if (w_fe) begin
            if (w_can_retry) begin
              r_retry <= r_retry + 2'd1;
              r_state <= B_FF;
            end else begin
              r_init_fail <= 1'b1;
              r_state     <= B_FAIL;
            end
          end else if (w_rsp_tmo) begin
            r_init_fail <= 1'b1;
            r_state     <= B_FAIL;
          end
        end
        B_BAT: begin
          if (w_aa) begin
            r_state <= B_F4;
          end else if (w_fc || w_bat_tmo) begin
            r_init_fail <= 1'b1;
            r_state     <= B_FAIL;
          end
        end
        B_F4: begin
          r_wr_en   <= 1'b1;
          r_wr_data <= 8'hF4;
          r_state   <= B_F4W;
        end
        B_F4W: begin
          if (bus.i_wr_done) begin
            r_timer <= '0;
            r_state <= B_F4A;
          end
        end
        B_F4A: begin
          if (w_fa) begin
            r_retry     <= '0;
            r_init_done <= 1'b1;
            r_state     <= S_IDLE;
          end else if (w_fe) begin
            if (w_can_retry) begin
              r_retry <= r_retry + 2'd1;
              r_state <= B_F4;
            end else begin
              r_init_fail <= 1'b1;
              r_state     <= B_FAIL;
            end
          end else if (w_rsp_tmo) begin
            r_init_fail <= 1'b1;
            r_state     <= B_FAIL;
          end
        end
        B_FAIL: begin
          r_init_fail <= 1'b1;
        end
        S_IDLE: begin
          if (|bus.i_req) begin
            r_gnt   <= w_win;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_wr_data <= w_cmd;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          r_wr_en <= 1'b1;
          r_state <= S_WAITW;
        end
        S_WAITW: begin
          if (bus.i_wr_done) begin
            r_timer <= '0;
            r_state <= S_WAITR;
          end
        end
        S_WAITR: begin
          if (w_fa) begin
            r_ack   <= w_gvec;
            r_retry <= '0;
            r_ptr   <= r_gnt;
            r_state <= S_IDLE;
          end else if (w_fe && w_can_retry) begin
            r_retry <= r_retry + 2'd1;
            r_state <= S_SEND;
          end else if (w_fe || w_rsp_tmo) begin
            r_err   <= w_gvec;
            r_retry <= '0;
            r_ptr   <= r_gnt;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= B_FF;
      endcase
    end
  end

  assign bus.o_ack       = r_ack;
  assign bus.o_err       = r_err;
  assign bus.o_wr_en     = r_wr_en;
  assign bus.o_wr_data   = r_wr_data;
  assign bus.o_rx_en     = r_rx_en;
  assign bus.o_rx_data   = r_rx_data;
  assign bus.o_init_done = r_init_done;
  assign bus.o_init_fail = r_init_fail;

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// Bench for ps2_cmd_sched: plays write engine and PS/2 device, checks outcomes
// against a transaction-level model of arbitration, retries and timeouts.
module tb_ps2_cmd_sched;
  localparam int RSP  = 100;
  localparam int MAXR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  int   wr_cnt = 0;
  logic [1:0] req_lv = 2'b00;
  int   mdl_ptr = 0;

  ps2_cmd_sched_if bus ();

  ps2_cmd_sched #(
    .RSP_TMO   (24'd100),
    .BAT_TMO   (26'd2000),
    .MAX_RETRY (2'd3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_wr_en === 1'b1) wr_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'h00;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      if (bus.o_wr_en === 1'b1) begin
        ok = 1'b1;
        d  = bus.o_wr_data;
      end
    end
  endtask

  task automatic send_done();
    repeat (3) tick();
    bus.i_wr_done = 1'b1;
    tick();
    bus.i_wr_done = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    bus.i_rx_en   = 1'b1;
    bus.i_rx_data = b;
    tick();
    bus.i_rx_en   = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, bus.o_wr_en, 0);
    check({tag, "_wr_data"}, bus.o_wr_data, 0);
    check({tag, "_ack_err"}, {bus.o_ack, bus.o_err}, 0);
    check({tag, "_rx"}, {bus.o_rx_en, bus.o_rx_data}, 0);
    check({tag, "_init"}, {bus.o_init_done, bus.o_init_fail}, 0);
  endtask

  task automatic boot();
    logic [7:0] d;
    bit ok;
    int w0;
    w0 = wr_cnt;
    wait_wr(d, ok);
    check("boot_ff_seen", ok, 1);
    check("boot_ff_data", d, 8'hFF);
    send_done();
    repeat (2) tick();
    rx_pulse(8'hFA);
    repeat (500) tick();
    rx_pulse(8'h55);
    check("boot_no_fwd", bus.o_rx_en, 0);
    repeat (500) tick();
    check("boot_not_done_yet", bus.o_init_done, 0);
    rx_pulse(8'hAA);
    wait_wr(d, ok);
    check("boot_f4_seen", ok, 1);
    check("boot_f4_data", d, 8'hF4);
    send_done();
    repeat (2) tick();
    rx_pulse(8'hFA);
    check("boot_init_done", {bus.o_init_done, bus.o_init_fail}, 2'b10);
    check("boot_wr_pulses", wr_cnt - w0, 2);
    tick();
  endtask

  // Serve the next command: model picks the winner and the outcome from the
  // response script (n_fe FE bytes, then FA or silence).
  task automatic serve_one(input int n_fe, input bit fin_fa, input bit scan);
    int g;
    int w0;
    int exp_wr;
    int n;
    bit exp_ok;
    bit ok;
    logic [7:0] exp_b;
    logic [7:0] d;
    logic [7:0] sb;
    logic [1:0] gv;
    g      = (req_lv == 2'b11) ? (1 - mdl_ptr) : (req_lv[1] ? 1 : 0);
    exp_b  = (g == 1) ? bus.i_cmd1 : bus.i_cmd0;
    gv     = (g == 1) ? 2'b10 : 2'b01;
    exp_wr = (n_fe > MAXR) ? MAXR + 1 : n_fe + 1;
    exp_ok = (n_fe > MAXR) ? 1'b0 : fin_fa;
    w0     = wr_cnt;
    for (int a = 0; a <= MAXR; a++) begin
      wait_wr(d, ok);
      check("cmd_wr_seen", ok, 1);
      check("cmd_wr_data", d, exp_b);
      send_done();
      n = 0;
      if (scan && a == 0) begin
        sb = 8'($urandom_range(0, 255));
        if (sb == 8'hFA || sb == 8'hFE) sb = 8'h1C;
        repeat (2) tick();
        rx_pulse(sb);
        n = 3;
        check("waitr_scan_en", bus.o_rx_en, 1);
        check("waitr_scan_data", bus.o_rx_data, sb);
      end
      if (a < n_fe) begin
        repeat (2) tick();
        rx_pulse(8'hFE);
        if (a == MAXR) break;
        check("fe_no_pulse", {bus.o_ack, bus.o_err}, 0);
      end else if (fin_fa) begin
        repeat (2) tick();
        rx_pulse(8'hFA);
        break;
      end else begin
        while (bus.o_err === 2'b00 && n < RSP + 20) begin
          tick();
          n++;
        end
        check("tmo_cycles", n, RSP);
        break;
      end
    end
    check("done_ack", bus.o_ack, exp_ok ? gv : 2'b00);
    check("done_err", bus.o_err, exp_ok ? 2'b00 : gv);
    req_lv[g] = 1'b0;
    bus.i_req = req_lv;
    mdl_ptr   = g;
    check("cmd_wr_pulses", wr_cnt - w0, exp_wr);
    tick();
    check("pulse_one_cycle", {bus.o_ack, bus.o_err}, 0);
  endtask

  initial begin
    logic [7:0] d;
    bit ok;
    int w0;
    bus.i_req     = 2'b00;
    bus.i_cmd0    = 8'h00;
    bus.i_cmd1    = 8'h00;
    bus.i_wr_done = 1'b0;
    bus.i_rx_en   = 1'b0;
    bus.i_rx_data = 8'h00;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;

    boot();

    // Both request together: ptr starts at 0 so requester 1 goes first.
    bus.i_cmd0 = 8'hED;
    bus.i_cmd1 = 8'hF3;
    req_lv     = 2'b11;
    bus.i_req  = req_lv;
    serve_one(0, 1'b1, 1'b0);
    serve_one(0, 1'b1, 1'b0);

    bus.i_cmd0 = 8'hF3;
    req_lv     = 2'b01;
    bus.i_req  = req_lv;
    serve_one(3, 1'b1, 1'b0);

    bus.i_cmd0 = 8'hED;
    req_lv     = 2'b01;
    bus.i_req  = req_lv;
    serve_one(4, 1'b1, 1'b0);

    bus.i_cmd1 = 8'hF2;
    req_lv     = 2'b10;
    bus.i_req  = req_lv;
    serve_one(0, 1'b0, 1'b0);

    repeat (3) tick();
    rx_pulse(8'h1C);
    check("idle_scan_en", bus.o_rx_en, 1);
    check("idle_scan_data", bus.o_rx_data, 8'h1C);
    tick();
    check("idle_scan_one_cycle", bus.o_rx_en, 0);

    for (int it = 0; it < 14; it++) begin
      logic [1:0] add;
      add = 2'($urandom_range(1, 3));
      if (add[0] && !req_lv[0]) bus.i_cmd0 = 8'($urandom_range(0, 255));
      if (add[1] && !req_lv[1]) bus.i_cmd1 = 8'($urandom_range(0, 255));
      req_lv    = req_lv | add;
      bus.i_req = req_lv;
      serve_one($urandom_range(0, 4), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
    end
    for (int k = 0; k < 2 && req_lv != 2'b00; k++) serve_one(0, 1'b1, 1'b0);

    // Reset while waiting for the device response.
    bus.i_cmd0 = 8'hF0;
    req_lv     = 2'b01;
    bus.i_req  = req_lv;
    wait_wr(d, ok);
    check("rst_mid_wr_seen", ok, 1);
    send_done();
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    req_lv    = 2'b00;
    bus.i_req = req_lv;
    mdl_ptr   = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    boot();

    // BAT failure: FC after the FF ack parks the block in the fail state.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_wr(d, ok);
    check("fc_ff_data", d, 8'hFF);
    send_done();
    repeat (2) tick();
    rx_pulse(8'hFA);
    repeat (10) tick();
    rx_pulse(8'hFC);
    check("fc_init_fail", {bus.o_init_done, bus.o_init_fail}, 2'b01);
    w0        = wr_cnt;
    bus.i_req = 2'b01;
    repeat (20) tick();
    check("fc_no_writes", wr_cnt - w0, 0);
    check("fc_sticky", bus.o_init_fail, 1);
    bus.i_req = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
